// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the regfile write-back arbiter signals: execute/slow-unit results in,
// regfile write port and decode busy status out.
interface regfile_wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: fast_valid has no ready and is always taken; a slow result transfers
  // on a cycle where slow_valid && slow_ready, and slow_valid/dest/data must hold
  // until that cycle. rf_load is a one-cycle strobe with no back-pressure.
  logic            fast_valid;
  logic [4:0]      fast_dest;
  logic [XLEN-1:0] fast_data;
  logic            slow_valid;
  logic            slow_ready;
  logic [4:0]      slow_dest;
  logic [XLEN-1:0] slow_data;
  logic            rf_load;
  logic [4:0]      rf_dest;
  logic [XLEN-1:0] rf_in;
  logic [4:0]      query_a;
  logic [4:0]      query_b;
  logic            busy_a;
  logic            busy_b;
  logic [CW-1:0]   count;

  modport master (
    output fast_valid, fast_dest, fast_data, slow_valid, slow_dest, slow_data,
    output query_a, query_b,
    input  slow_ready, rf_load, rf_dest, rf_in, busy_a, busy_b, count
  );

  modport slave (
    input  fast_valid, fast_dest, fast_data, slow_valid, slow_dest, slow_data,
    input  query_a, query_b,
    output slow_ready, rf_load, rf_dest, rf_in, busy_a, busy_b, count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: fast execute results win, slow results drain from a FIFO.
// Optional WAW squash of buffered entries by younger fast writes: WB_WAW_SQUASH_EN.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]       dest_q [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d, squash_mask;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rf_load_q, rf_load_d;
  logic [4:0]       rf_dest_q, rf_dest_d;
  logic [XLEN-1:0]  rf_in_q, rf_in_d;
  logic             fast_sel, push, pop, push_live;

  assign wb.slow_ready = rst_n && (count_q != CW'(DEPTH));
  assign fast_sel      = wb.fast_valid && (wb.fast_dest != 5'd0);
  assign push          = wb.slow_valid && wb.slow_ready && (wb.slow_dest != 5'd0);
  assign pop           = !fast_sel && (count_q != '0);

`ifdef WB_WAW_SQUASH_EN
  // The fast result is the youngest write, so older buffered writes to that reg are dead.
  always_comb begin
    squash_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fast_sel && (dest_q[i] == wb.fast_dest)) squash_mask[i] = 1'b1;
    end
  end
  assign push_live = !(fast_sel && (wb.slow_dest == wb.fast_dest));
`else
  assign squash_mask = '0;
  assign push_live   = 1'b1;
`endif

  always_comb begin
    live_d  = live_q & ~squash_mask;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end
    if (push) begin
      live_d[tail_q] = push_live;
      tail_d         = tail_q + 1'b1;
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // rf_dest/rf_in hold their last value whenever no write is issued.
  always_comb begin
    rf_load_d = 1'b0;
    rf_dest_d = rf_dest_q;
    rf_in_d   = rf_in_q;
    if (fast_sel) begin
      rf_load_d = 1'b1;
      rf_dest_d = wb.fast_dest;
      rf_in_d   = wb.fast_data;
    end else if (pop && live_q[head_q]) begin
      rf_load_d = 1'b1;
      rf_dest_d = dest_q[head_q];
      rf_in_d   = data_q[head_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rf_load_q <= 1'b0;
      rf_dest_q <= 5'd0;
      rf_in_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= 5'd0;
        data_q[i] <= '0;
      end
    end else begin
      live_q    <= live_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rf_load_q <= rf_load_d;
      rf_dest_q <= rf_dest_d;
      rf_in_q   <= rf_in_d;
      if (push) begin
        dest_q[tail_q] <= wb.slow_dest;
        data_q[tail_q] <= wb.slow_data;
      end
    end
  end

  // Popped entries lose their live bit, so the write sitting in rf_* never reads as busy.
  always_comb begin
    wb.busy_a = 1'b0;
    wb.busy_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (dest_q[i] == wb.query_a)) wb.busy_a = 1'b1;
      if (live_q[i] && (dest_q[i] == wb.query_b)) wb.busy_b = 1'b1;
    end
    if (wb.query_a == 5'd0) wb.busy_a = 1'b0;
    if (wb.query_b == 5'd0) wb.busy_b = 1'b0;
  end

  assign wb.rf_load = rf_load_q;
  assign wb.rf_dest = rf_dest_q;
  assign wb.rf_in   = rf_in_q;
  assign wb.count   = count_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes queued at issue, popped by a negedge monitor.
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int W     = 5 + XLEN;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  logic [W-1:0] exp_q[$];

  regfile_wb_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) wb ();

  regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb   (wb.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fast(input logic v, input logic [4:0] d, input logic [XLEN-1:0] x);
    wb.fast_valid = v;
    wb.fast_dest  = d;
    wb.fast_data  = x;
  endtask

  task automatic drive_slow(input logic v, input logic [4:0] d, input logic [XLEN-1:0] x);
    wb.slow_valid = v;
    wb.slow_dest  = d;
    wb.slow_data  = x;
  endtask

  task automatic expect_wr(input logic [4:0] d, input logic [XLEN-1:0] x);
    exp_q.push_back({d, x});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (wb.rf_load === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got dest %0d data 0x%0h, expected no write at %0t",
                 wb.rf_dest, wb.rf_in, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("wb_write", 64'({wb.rf_dest, wb.rf_in}), 64'(e));
      end
    end
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    drive_fast(1'b0, 5'd0, '0);
    drive_slow(1'b0, 5'd0, '0);
    wb.query_a = 5'd0;
    wb.query_b = 5'd0;

    // reset state
    repeat (2) tick();
    chk("reset_rf_load", 64'(wb.rf_load), 64'd0);
    chk("reset_rf_dest", 64'(wb.rf_dest), 64'd0);
    chk("reset_rf_in", 64'(wb.rf_in), 64'd0);
    chk("reset_slow_ready", 64'(wb.slow_ready), 64'd0);
    chk("reset_count", 64'(wb.count), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("release_slow_ready", 64'(wb.slow_ready), 64'd1);

    // fast path: one-cycle latency, then hold
    drive_fast(1'b1, 5'd5, 32'hDEADBEEF);
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    drive_fast(1'b0, 5'd0, '0);
    chk("fast_lat_load", 64'(wb.rf_load), 64'd1);
    chk("fast_lat_dest", 64'(wb.rf_dest), 64'd5);
    chk("fast_lat_data", 64'(wb.rf_in), 64'hDEADBEEF);
    tick();
    chk("hold_load", 64'(wb.rf_load), 64'd0);
    chk("hold_dest", 64'(wb.rf_dest), 64'd5);
    chk("hold_data", 64'(wb.rf_in), 64'hDEADBEEF);

    // fill under fast pressure, then drain in order
    for (int k = 1; k <= 4; k++) begin
      drive_fast(1'b1, 5'd20, 32'h2000 + k);
      drive_slow(1'b1, 5'(k), 32'h1000 + k);
      chk("fill_slow_ready", 64'(wb.slow_ready), 64'd1);
      expect_wr(5'd20, 32'h2000 + k);
      tick();
    end
    drive_fast(1'b0, 5'd0, '0);
    drive_slow(1'b0, 5'd0, '0);
    chk("full_count", 64'(wb.count), 64'd4);
    chk("full_slow_ready", 64'(wb.slow_ready), 64'd0);
    for (int k = 1; k <= 4; k++) expect_wr(5'(k), 32'h1000 + k);
    tick();
    chk("drain1_slow_ready", 64'(wb.slow_ready), 64'd1);
    chk("drain1_count", 64'(wb.count), 64'd3);
    repeat (3) tick();
    chk("drain_done_count", 64'(wb.count), 64'd0);

    // fast dest 0 leaves the slot to the buffer; slow dest 0 is dropped
    drive_slow(1'b1, 5'd7, 32'h77);
    tick();
    drive_fast(1'b1, 5'd0, 32'hBAD0);
    drive_slow(1'b1, 5'd0, 32'hBAD1);
    expect_wr(5'd7, 32'h77);
    tick();
    drive_fast(1'b0, 5'd0, '0);
    drive_slow(1'b0, 5'd0, '0);
    chk("x0_pop_load", 64'(wb.rf_load), 64'd1);
    chk("x0_drop_count", 64'(wb.count), 64'd0);

    // WAW: buffered dest 9 vs younger fast dest 9
    wb.query_a = 5'd9;
    drive_slow(1'b1, 5'd9, 32'hA);
    tick();
    drive_slow(1'b0, 5'd0, '0);
    chk("waw_busy_before", 64'(wb.busy_a), 64'd1);
    chk("waw_count_before", 64'(wb.count), 64'd1);
    drive_fast(1'b1, 5'd9, 32'hB);
    expect_wr(5'd9, 32'hB);
    tick();
    drive_fast(1'b0, 5'd0, '0);
`ifdef WB_WAW_SQUASH_EN
    chk("waw_busy_after", 64'(wb.busy_a), 64'd0);
    chk("waw_count_after", 64'(wb.count), 64'd1);
    tick();
    chk("waw_dead_pop_load", 64'(wb.rf_load), 64'd0);
`else
    chk("waw_busy_after", 64'(wb.busy_a), 64'd1);
    expect_wr(5'd9, 32'hA);
    tick();
    chk("waw_old_pop_load", 64'(wb.rf_load), 64'd1);
`endif
    chk("waw_count_end", 64'(wb.count), 64'd0);

    // WAW with the slow entry accepted in the same cycle as the fast write
    wb.query_b = 5'd11;
    drive_slow(1'b1, 5'd11, 32'hC1);
    drive_fast(1'b1, 5'd11, 32'hC2);
    expect_wr(5'd11, 32'hC2);
    tick();
    drive_fast(1'b0, 5'd0, '0);
    drive_slow(1'b0, 5'd0, '0);
    chk("waw_same_count", 64'(wb.count), 64'd1);
`ifdef WB_WAW_SQUASH_EN
    chk("waw_same_busy", 64'(wb.busy_b), 64'd0);
    tick();
    chk("waw_same_dead_load", 64'(wb.rf_load), 64'd0);
`else
    chk("waw_same_busy", 64'(wb.busy_b), 64'd1);
    expect_wr(5'd11, 32'hC1);
    tick();
    chk("waw_same_old_load", 64'(wb.rf_load), 64'd1);
`endif
    chk("waw_same_count_end", 64'(wb.count), 64'd0);

    // busy tracking over three held entries, with a push+pop cycle
    wb.query_a = 5'd13;
    wb.query_b = 5'd14;
    for (int k = 0; k < 3; k++) begin
      drive_fast(1'b1, 5'd21, 32'h3000 + k);
      drive_slow(1'b1, 5'(12 + k), 32'h4000 + k);
      expect_wr(5'd21, 32'h3000 + k);
      tick();
    end
    drive_fast(1'b0, 5'd0, '0);
    chk("busy3_count", 64'(wb.count), 64'd3);
    chk("busy3_a", 64'(wb.busy_a), 64'd1);
    chk("busy3_b", 64'(wb.busy_b), 64'd1);
    for (int k = 0; k < 4; k++) expect_wr(5'(12 + k), 32'h4000 + k);
    drive_slow(1'b1, 5'd15, 32'h4003);
    tick();
    drive_slow(1'b0, 5'd0, '0);
    chk("pushpop_count", 64'(wb.count), 64'd3);
    chk("pushpop_busy_a", 64'(wb.busy_a), 64'd1);
    tick();
    chk("pop13_busy_a", 64'(wb.busy_a), 64'd0);
    chk("pop13_busy_b", 64'(wb.busy_b), 64'd1);
    tick();
    chk("pop14_busy_b", 64'(wb.busy_b), 64'd0);
    tick();
    chk("busy_drain_count", 64'(wb.count), 64'd0);
    wb.query_a = 5'd0;
    chk("busy_x0", 64'(wb.busy_a), 64'd0);

    // reset mid-traffic discards buffered results
    wb.query_a = 5'd16;
    for (int k = 0; k < 2; k++) begin
      drive_fast(1'b1, 5'd22, 32'h5000 + k);
      drive_slow(1'b1, 5'(16 + k), 32'h6000 + k);
      expect_wr(5'd22, 32'h5000 + k);
      tick();
    end
    drive_fast(1'b0, 5'd0, '0);
    drive_slow(1'b0, 5'd0, '0);
    chk("pre_reset_busy", 64'(wb.busy_a), 64'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_load", 64'(wb.rf_load), 64'd0);
    chk("midrst_slow_ready", 64'(wb.slow_ready), 64'd0);
    chk("midrst_count", 64'(wb.count), 64'd0);
    chk("midrst_busy", 64'(wb.busy_a), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_slow_ready", 64'(wb.slow_ready), 64'd1);
    chk("post_rst_count", 64'(wb.count), 64'd0);

    // report
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
